// File: rtl/sp_pkg.sv
// sp_pkg: shared widths, imem responder state encoding and address checks
package sp_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int ADDR_WIDTH = 16;
  localparam int IMEM_DEPTH_DEFAULT = 256;
  localparam int IMEM_LAT_W = 4;

  typedef enum logic [1:0] {IMEM_IDLE, IMEM_WAIT, IMEM_RESP} imem_state_e;

  // Misaligned (odd byte) or past the end of a depth-word store
  function automatic logic imem_bad(input logic [ADDR_WIDTH-1:0] a, input int depth);
    return a[0] || (int'(a[ADDR_WIDTH-1:1]) >= depth);
  endfunction
endpackage

// File: rtl/imem_responder_if.sv
// imem_responder_if: fetch-side req/ack bus between the fetch stage and instruction memory
interface imem_responder_if;
  import sp_pkg::*;
  logic                  req;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  ack;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  err;
  logic                  busy;
  modport master(output req, addr, input ack, rdata, err, busy);
  modport slave(input req, addr, output ack, rdata, err, busy);
endinterface

// File: rtl/imem_array.sv
// imem_array: instruction store, one synchronous write port and one combinational read port
module imem_array #(
  parameter int DEPTH = 256,
  parameter int DW    = 16,
  parameter int IW    = 8
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [IW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [IW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem_q [DEPTH];

  // Store is deliberately unreset; contents come from the loader
  always_ff @(posedge clk_i)
    if (we_i) mem_q[waddr_i] <= wdata_i;

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/imem_responder.sv
// imem_responder: memory end of the imem fetch bus with programmable wait states and error flagging
module imem_responder
  import sp_pkg::*;
#(
  parameter int DEPTH   = IMEM_DEPTH_DEFAULT,
  parameter int LATENCY = 0
) (
  input  logic                  clk_i,
  input  logic                  arst_ni,
  imem_responder_if.slave       bus,
  input  logic                  load_we_i,
  input  logic [ADDR_WIDTH-1:0] load_addr_i,
  input  logic [DATA_WIDTH-1:0] load_wdata_i
);
  localparam int IW = $clog2(DEPTH);

  if (LATENCY > 2**IMEM_LAT_W - 1 || DEPTH > 2**(ADDR_WIDTH-1)) begin : g_param_check
    $fatal(1, "imem_responder: LATENCY or DEPTH out of range");
  end

  imem_state_e           state_q;
  logic [IMEM_LAT_W-1:0] cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  ack_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  rd_bad;
  logic                  load_ok;

  // While waiting the latched address is looked up; otherwise the incoming one (zero-latency accept)
  assign rd_addr = (state_q == IMEM_WAIT) ? addr_q : bus.addr;
  assign rd_bad  = imem_bad(rd_addr, DEPTH);
  assign load_ok = load_we_i && !imem_bad(load_addr_i, DEPTH);

  imem_array #(.DEPTH(DEPTH), .DW(DATA_WIDTH), .IW(IW)) u_array (
    .clk_i  (clk_i),
    .we_i   (load_ok),
    .waddr_i(load_addr_i[IW:1]),
    .wdata_i(load_wdata_i),
    .raddr_i(rd_addr[IW:1]),
    .rdata_o(rd_word)
  );

  // Fetch FSM; the response registers are loaded on the edge that enters RESP and clear otherwise
  always_ff @(posedge clk_i or negedge arst_ni)
    if (!arst_ni) begin
      state_q <= IMEM_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      if (state_q == IMEM_WAIT) begin
        if (cnt_q == '0) begin
          state_q <= IMEM_RESP;
          ack_q   <= 1'b1;
          err_q   <= rd_bad;
          rdata_q <= rd_bad ? '0 : rd_word;
        end else cnt_q <= cnt_q - 1'b1;
      end else if (bus.req) begin
        addr_q <= bus.addr;
        if (LATENCY == 0) begin
          state_q <= IMEM_RESP;
          ack_q   <= 1'b1;
          err_q   <= rd_bad;
          rdata_q <= rd_bad ? '0 : rd_word;
        end else begin
          state_q <= IMEM_WAIT;
          cnt_q   <= IMEM_LAT_W'(LATENCY - 1);
        end
      end else state_q <= IMEM_IDLE;
    end

  assign bus.ack   = ack_q;
  assign bus.err   = err_q;
  assign bus.rdata = rdata_q;
  assign bus.busy  = (state_q == IMEM_WAIT) || (state_q == IMEM_RESP && bus.req);
endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: randomized checks of four responders (latency 0,2,3,5) against a word-array model
module tb_imem_responder;
  import sp_pkg::*;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req [4];
  logic [15:0] addr [4];
  logic        ack [4];
  logic [15:0] rdata [4];
  logic        err [4];
  logic        busy [4];
  logic        load_we;
  logic [15:0] load_addr;
  logic [15:0] load_wdata;
  logic [15:0] mem [DEPTH];
  int total = 0;
  int bad = 0;

  imem_responder_if if_a ();
  imem_responder_if if_b ();
  imem_responder_if if_c ();
  imem_responder_if if_d ();

  assign if_a.req = req[0];
  assign if_a.addr = addr[0];
  assign ack[0] = if_a.ack;
  assign rdata[0] = if_a.rdata;
  assign err[0] = if_a.err;
  assign busy[0] = if_a.busy;
  assign if_b.req = req[1];
  assign if_b.addr = addr[1];
  assign ack[1] = if_b.ack;
  assign rdata[1] = if_b.rdata;
  assign err[1] = if_b.err;
  assign busy[1] = if_b.busy;
  assign if_c.req = req[2];
  assign if_c.addr = addr[2];
  assign ack[2] = if_c.ack;
  assign rdata[2] = if_c.rdata;
  assign err[2] = if_c.err;
  assign busy[2] = if_c.busy;
  assign if_d.req = req[3];
  assign if_d.addr = addr[3];
  assign ack[3] = if_d.ack;
  assign rdata[3] = if_d.rdata;
  assign err[3] = if_d.err;
  assign busy[3] = if_d.busy;

  imem_responder #(.DEPTH(DEPTH), .LATENCY(0)) u_l0 (
    .clk_i(clk), .arst_ni(arst_n), .bus(if_a.slave),
    .load_we_i(load_we), .load_addr_i(load_addr), .load_wdata_i(load_wdata));
  imem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_l2 (
    .clk_i(clk), .arst_ni(arst_n), .bus(if_b.slave),
    .load_we_i(load_we), .load_addr_i(load_addr), .load_wdata_i(load_wdata));
  imem_responder #(.DEPTH(DEPTH), .LATENCY(3)) u_l3 (
    .clk_i(clk), .arst_ni(arst_n), .bus(if_c.slave),
    .load_we_i(load_we), .load_addr_i(load_addr), .load_wdata_i(load_wdata));
  imem_responder #(.DEPTH(DEPTH), .LATENCY(5)) u_l5 (
    .clk_i(clk), .arst_ni(arst_n), .bus(if_d.slave),
    .load_we_i(load_we), .load_addr_i(load_addr), .load_wdata_i(load_wdata));

  function automatic int lat(input int k);
    return k == 0 ? 0 : k == 1 ? 2 : k == 2 ? 3 : 5;
  endfunction

  function automatic logic e_err(input logic [15:0] a);
    return (a % 2 != 0) || (int'(a) / 2 >= DEPTH);
  endfunction

  function automatic logic [15:0] e_word(input logic [15:0] a);
    return e_err(a) ? 16'h0 : mem[int'(a) / 2];
  endfunction

  function automatic logic [15:0] pick(input bit rnd, input int j);
    if (!rnd) return 16'(2 * j);
    if ($urandom_range(0, 7) == 0) return 16'($urandom);
    return 16'(2 * $urandom_range(0, DEPTH - 1) + ($urandom_range(0, 9) == 0 ? 1 : 0));
  endfunction

  task automatic load(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    load_we = 1'b1;
    load_addr = a;
    load_wdata = d;
    @(negedge clk);
    load_we = 1'b0;
    if (!e_err(a)) mem[int'(a) / 2] = d;
  endtask

  task automatic read1(input int k, input logic [15:0] a, input string nm);
    int l;
    logic [15:0] ew;
    logic ee;
    l = lat(k);
    ee = e_err(a);
    ew = e_word(a);
    @(negedge clk);
    req[k] = 1'b1;
    addr[k] = a;
    @(negedge clk);
    req[k] = 1'b0;
    addr[k] = 16'($urandom);
    #1;
    for (int i = 0; i < l; i++) begin
      total++;
      if ({ack[k], busy[k]} !== 2'b01) begin
        bad++;
        $display("FAIL %s wait%0d ack/busy got %b%b want 01", nm, i, ack[k], busy[k]);
      end
      @(negedge clk);
      #1;
    end
    total++;
    if ({ack[k], err[k], rdata[k], busy[k]} !== {1'b1, ee, ew, 1'b0}) begin
      bad++;
      $display("FAIL %s resp ack=%b err=%b rdata=%h busy=%b want 1 %b %h 0", nm, ack[k], err[k], rdata[k], busy[k], ee, ew);
    end
    @(negedge clk);
    #1;
    total++;
    if ({ack[k], err[k], rdata[k], busy[k]} !== 19'h0) begin
      bad++;
      $display("FAIL %s idle ack=%b err=%b rdata=%h busy=%b want all 0", nm, ack[k], err[k], rdata[k], busy[k]);
    end
  endtask

  // req held high; ack at sample j iff j-1-l is a non-negative multiple of l+1, serving addr from j-l-1
  task automatic test_stream(input int k, input int n, input bit rnd, input string nm);
    int l;
    logic [15:0] ah [64];
    logic [15:0] a;
    logic ea;
    l = lat(k);
    @(negedge clk);
    req[k] = 1'b1;
    ah[0] = pick(rnd, 0);
    addr[k] = ah[0];
    for (int j = 1; j <= n * (l + 1); j++) begin
      @(negedge clk);
      #1;
      ea = (j - 1 - l >= 0) && ((j - 1 - l) % (l + 1) == 0);
      a = ea ? ah[j - l - 1] : 16'h0;
      total++;
      if ({ack[k], err[k], rdata[k], busy[k]} !== {ea, ea && e_err(a), ea ? e_word(a) : 16'h0, 1'b1}) begin
        bad++;
        $display("FAIL %s cyc%0d ack=%b err=%b rdata=%h busy=%b want %b %b %h 1", nm, j, ack[k], err[k], rdata[k], busy[k],
                 ea, ea && e_err(a), ea ? e_word(a) : 16'h0);
      end
      ah[j] = pick(rnd, j);
      addr[k] = ah[j];
    end
    req[k] = 1'b0;
    @(negedge clk);
    #1;
    total++;
    if ({ack[k], busy[k]} !== 2'b00) begin
      bad++;
      $display("FAIL %s drain ack=%b busy=%b want 00", nm, ack[k], busy[k]);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < DEPTH; i++) load(16'(2 * i), 16'($urandom));
    req[0] = 1'b1;
    addr[0] = 16'h0;
    req[2] = 1'b1;
    addr[2] = 16'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      total++;
      if ({ack[0], rdata[0], busy[0], ack[2], rdata[2], busy[2]} !== 36'h0) begin
        bad++;
        $display("FAIL reset_hold ack=%b/%b rdata=%h/%h busy=%b/%b want all 0", ack[0], ack[2], rdata[0], rdata[2], busy[0], busy[2]);
      end
    end
    @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if ({ack[0], err[0], rdata[0], busy[0]} !== {1'b1, 1'b0, mem[0], 1'b1}) begin
      bad++;
      $display("FAIL reset_first_l0 ack=%b err=%b rdata=%h busy=%b want 1 0 %h 1", ack[0], err[0], rdata[0], busy[0], mem[0]);
    end
    req[0] = 1'b0;
    req[2] = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      if (j > 1) begin
        @(negedge clk);
        #1;
      end
      total++;
      if ({ack[2], rdata[2], busy[2]} !== (j < 4 ? {1'b0, 16'h0, 1'b1} : {1'b1, mem[0], 1'b0})) begin
        bad++;
        $display("FAIL reset_first_l3 cyc%0d ack=%b rdata=%h busy=%b", j, ack[2], rdata[2], busy[2]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_stream_basic();
    load(16'h0, 16'h1111);
    load(16'h2, 16'h2222);
    load(16'h4, 16'h3333);
    load(16'h6, 16'h4444);
    test_stream(0, 4, 1'b0, "stream_l0");
  endtask

  task automatic test_latency();
    load(16'h8, 16'hBEEF);
    read1(2, 16'h8, "lat3_beef");
    load(16'h9, 16'h0BAD);
    load(16'(2 * DEPTH + 8), 16'hDEAD);
    read1(2, 16'h8, "lat3_dropped_loads");
    read1(1, 16'h8, "lat2_beef");
    read1(3, 16'h8, "lat5_beef");
  endtask

  task automatic test_errors();
    read1(0, 16'h0003, "err_misaligned_l0");
    read1(0, 16'(2 * DEPTH), "err_range_l0");
    read1(2, 16'h0003, "err_misaligned_l3");
    read1(1, 16'hFFFE, "err_range_l2");
  endtask

  task automatic test_read_before_write();
    logic [15:0] old;
    load(16'd10, 16'h5555);
    old = mem[5];
    @(negedge clk);
    req[1] = 1'b1;
    addr[1] = 16'd10;
    @(negedge clk);
    req[1] = 1'b0;
    @(negedge clk);
    load_we = 1'b1;
    load_addr = 16'd10;
    load_wdata = 16'hCAFE;
    @(negedge clk);
    load_we = 1'b0;
    mem[5] = 16'hCAFE;
    #1;
    total++;
    if ({ack[1], err[1], rdata[1]} !== {1'b1, 1'b0, old}) begin
      bad++;
      $display("FAIL rbw_old ack=%b err=%b rdata=%h want 1 0 %h", ack[1], err[1], rdata[1], old);
    end
    read1(1, 16'd10, "rbw_new");
  endtask

  task automatic test_back_to_back();
    test_stream(0, 40, 1'b1, "b2b_l0");
    test_stream(1, 15, 1'b1, "b2b_l2");
    test_stream(2, 10, 1'b1, "b2b_l3");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req[3] = 1'b1;
    addr[3] = 16'h4;
    @(negedge clk);
    req[3] = 1'b0;
    @(negedge clk);
    #1;
    total++;
    if (busy[3] !== 1'b1) begin
      bad++;
      $display("FAIL midreset_busy got %b want 1", busy[3]);
    end
    arst_n = 1'b0;
    #1;
    total++;
    if ({ack[3], err[3], rdata[3], busy[3]} !== 19'h0) begin
      bad++;
      $display("FAIL midreset_assert ack=%b err=%b rdata=%h busy=%b want all 0", ack[3], err[3], rdata[3], busy[3]);
    end
    @(negedge clk);
    arst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      total++;
      if ({ack[3], err[3], rdata[3], busy[3]} !== 19'h0) begin
        bad++;
        $display("FAIL midreset_after cyc%0d ack=%b err=%b rdata=%h busy=%b want all 0", i, ack[3], err[3], rdata[3], busy[3]);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      req[k] = 1'b0;
      addr[k] = 16'h0;
    end
    load_we = 1'b0;
    load_addr = 16'h0;
    load_wdata = 16'h0;
    test_reset();
    test_stream_basic();
    test_latency();
    test_errors();
    test_read_before_write();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
